// File: rtl/mem_access_controller_pkg.sv
// Shared widths, memLength codes, FSM state encoding and the op legality check
// for the load/store sequencer.
package mem_access_controller_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned REGADDR_WIDTH = 5;

    localparam logic [1:0] MemLenByte    = 2'd0;
    localparam logic [1:0] MemLenHalf    = 2'd1;
    localparam logic [1:0] MemLenIllegal = 2'd2;
    localparam logic [1:0] MemLenWord    = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWb   = 2'd2
    } state_e;

    // True when an issued op must be rejected without touching the bus.
    function automatic logic op_malformed(input logic       load,
                                          input logic       store,
                                          input logic [1:0] len,
                                          input logic [1:0] addr_lo);
        logic bad;
        bad = load && store;
        case (len)
            MemLenHalf:    bad = bad || addr_lo[0];
            MemLenWord:    bad = bad || (addr_lo != 2'b00);
            MemLenIllegal: bad = 1'b1;
            default:       bad = bad;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_formatter.sv
// Combinational byte-lane formatting: store replication/byte enables and
// load lane selection with sign or zero extension.
module mem_lane_formatter
    import mem_access_controller_pkg::*;
(
    input  logic [1:0]            st_len_i,
    input  logic [1:0]            st_addr_lo_i,
    input  logic [DATA_WIDTH-1:0] st_data_i,
    output logic [3:0]            st_byte_en_o,
    output logic [DATA_WIDTH-1:0] st_wdata_o,
    input  logic [1:0]            ld_len_i,
    input  logic [1:0]            ld_addr_lo_i,
    input  logic                  ld_unsigned_i,
    input  logic [DATA_WIDTH-1:0] ld_rdata_i,
    output logic [DATA_WIDTH-1:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_sign;

    always_comb begin
        st_byte_en_o = 4'b1111;
        st_wdata_o   = st_data_i;
        case (st_len_i)
            MemLenByte: begin
                st_byte_en_o = 4'b0001 << st_addr_lo_i;
                st_wdata_o   = {4{st_data_i[7:0]}};
            end
            MemLenHalf: begin
                st_byte_en_o = 4'b0011 << st_addr_lo_i;
                st_wdata_o   = {2{st_data_i[15:0]}};
            end
            default: begin
                st_byte_en_o = 4'b1111;
                st_wdata_o   = st_data_i;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_rdata_i[7:0];
        case (ld_addr_lo_i)
            2'd1:    ld_byte = ld_rdata_i[15:8];
            2'd2:    ld_byte = ld_rdata_i[23:16];
            2'd3:    ld_byte = ld_rdata_i[31:24];
            default: ld_byte = ld_rdata_i[7:0];
        endcase
        ld_half = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];

        ld_sign   = 1'b0;
        ld_data_o = ld_rdata_i;
        case (ld_len_i)
            MemLenByte: begin
                ld_sign   = ~ld_unsigned_i & ld_byte[7];
                ld_data_o = {{24{ld_sign}}, ld_byte};
            end
            MemLenHalf: begin
                ld_sign   = ~ld_unsigned_i & ld_half[15];
                ld_data_o = {{16{ld_sign}}, ld_half};
            end
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_controller.sv
// Multi-cycle load/store sequencer: accepts one decoded memory op, runs a
// req/ack bus transaction with timeout, and returns extended load data.
module mem_access_controller
    import mem_access_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TIMER_WIDTH    = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issueValid,
    input  logic                     load,
    input  logic                     store,
    input  logic                     loadUnsigned,
    input  logic [1:0]               memLength,
    input  logic [DATA_WIDTH-1:0]    address,
    input  logic [DATA_WIDTH-1:0]    storeData,
    input  logic [REGADDR_WIDTH-1:0] destReg,
    output logic                     stall,
    output logic                     memReq,
    output logic                     memWrite,
    output logic [DATA_WIDTH-1:0]    memAddr,
    output logic [3:0]               memByteEnable,
    output logic [DATA_WIDTH-1:0]    memWriteData,
    input  logic                     memAck,
    input  logic [DATA_WIDTH-1:0]    memReadData,
    output logic                     wbValid,
    output logic [REGADDR_WIDTH-1:0] wbReg,
    output logic [DATA_WIDTH-1:0]    wbData,
    output logic                     accessError
);

    localparam logic TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMER_WIDTH-1:0] TimerLast =
        (TIMEOUT_CYCLES == 0) ? '0 : TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                   state_q, state_d;
    logic                     mem_req_q, mem_req_d;
    logic                     mem_write_q, mem_write_d;
    logic [DATA_WIDTH-1:0]    mem_addr_q, mem_addr_d;
    logic [3:0]               mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [1:0]               ld_len_q, ld_len_d;
    logic [1:0]               ld_addr_lo_q, ld_addr_lo_d;
    logic                     ld_unsigned_q, ld_unsigned_d;
    logic [REGADDR_WIDTH-1:0] dest_reg_q, dest_reg_d;
    logic                     wb_valid_q, wb_valid_d;
    logic [REGADDR_WIDTH-1:0] wb_reg_q, wb_reg_d;
    logic [DATA_WIDTH-1:0]    wb_data_q, wb_data_d;
    logic                     access_error_q, access_error_d;
    logic [TIMER_WIDTH-1:0]   timer_q, timer_d;

    logic                  op_valid;
    logic                  op_err;
    logic [3:0]            fmt_be;
    logic [DATA_WIDTH-1:0] fmt_wdata;
    logic [DATA_WIDTH-1:0] fmt_ld_data;

    mem_lane_formatter u_formatter (
        .st_len_i      (memLength),
        .st_addr_lo_i  (address[1:0]),
        .st_data_i     (storeData),
        .st_byte_en_o  (fmt_be),
        .st_wdata_o    (fmt_wdata),
        .ld_len_i      (ld_len_q),
        .ld_addr_lo_i  (ld_addr_lo_q),
        .ld_unsigned_i (ld_unsigned_q),
        .ld_rdata_i    (memReadData),
        .ld_data_o     (fmt_ld_data)
    );

    assign op_valid = issueValid && (load || store);
    assign op_err   = op_malformed(load, store, memLength, address[1:0]);

    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_write_d    = mem_write_q;
        mem_addr_d     = mem_addr_q;
        mem_be_d       = mem_be_q;
        mem_wdata_d    = mem_wdata_q;
        ld_len_d       = ld_len_q;
        ld_addr_lo_d   = ld_addr_lo_q;
        ld_unsigned_d  = ld_unsigned_q;
        dest_reg_d     = dest_reg_q;
        wb_valid_d     = 1'b0;
        wb_reg_d       = wb_reg_q;
        wb_data_d      = wb_data_q;
        access_error_d = 1'b0;
        timer_d        = timer_q;
        stall          = 1'b0;

        case (state_q)
            StIdle: begin
                if (op_valid) begin
                    if (op_err) begin
                        access_error_d = 1'b1;
                    end else begin
                        stall         = 1'b1;
                        state_d       = StReq;
                        mem_req_d     = 1'b1;
                        mem_write_d   = store;
                        mem_addr_d    = {address[DATA_WIDTH-1:2], 2'b00};
                        mem_be_d      = fmt_be;
                        mem_wdata_d   = fmt_wdata;
                        ld_len_d      = memLength;
                        ld_addr_lo_d  = address[1:0];
                        ld_unsigned_d = loadUnsigned;
                        dest_reg_d    = destReg;
                        timer_d       = '0;
                    end
                end
            end
            StReq: begin
                stall = 1'b1;
                // An ack coinciding with the last timer cycle wins over the timeout.
                if (memAck) begin
                    mem_req_d = 1'b0;
                    if (mem_write_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d    = StWb;
                        wb_data_d  = fmt_ld_data;
                        wb_reg_d   = dest_reg_q;
                        wb_valid_d = (dest_reg_q != '0);
                    end
                end else if (TimeoutEn && (timer_q == TimerLast)) begin
                    mem_req_d      = 1'b0;
                    state_d        = StIdle;
                    access_error_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_WIDTH'(1);
                end
            end
            StWb: begin
                stall   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            mem_req_q      <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_be_q       <= '0;
            mem_wdata_q    <= '0;
            ld_len_q       <= '0;
            ld_addr_lo_q   <= '0;
            ld_unsigned_q  <= 1'b0;
            dest_reg_q     <= '0;
            wb_valid_q     <= 1'b0;
            wb_reg_q       <= '0;
            wb_data_q      <= '0;
            access_error_q <= 1'b0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_write_q    <= mem_write_d;
            mem_addr_q     <= mem_addr_d;
            mem_be_q       <= mem_be_d;
            mem_wdata_q    <= mem_wdata_d;
            ld_len_q       <= ld_len_d;
            ld_addr_lo_q   <= ld_addr_lo_d;
            ld_unsigned_q  <= ld_unsigned_d;
            dest_reg_q     <= dest_reg_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_q       <= wb_reg_d;
            wb_data_q      <= wb_data_d;
            access_error_q <= access_error_d;
            timer_q        <= timer_d;
        end
    end

    assign memReq        = mem_req_q;
    assign memWrite      = mem_write_q;
    assign memAddr       = mem_addr_q;
    assign memByteEnable = mem_be_q;
    assign memWriteData  = mem_wdata_q;
    assign wbValid       = wb_valid_q;
    assign wbReg         = wb_reg_q;
    assign wbData        = wb_data_q;
    assign accessError   = access_error_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: directed vector table, reset/timeout
// sequences and randomized ops checked against an arithmetic reference model.
module tb_mem_access_controller;

    localparam int unsigned Timeout = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issueValid = 1'b0, load = 1'b0, store = 1'b0, loadUnsigned = 1'b0;
    logic [1:0]  memLength = 2'd0;
    logic [31:0] address = '0, storeData = '0;
    logic [4:0]  destReg = '0;
    logic        stall, memReq, memWrite, memAck = 1'b0;
    logic [31:0] memAddr, memWriteData, memReadData = '0;
    logic [3:0]  memByteEnable;
    logic        wbValid, accessError;
    logic [4:0]  wbReg;
    logic [31:0] wbData;

    int errors = 0;
    int checks = 0;

    mem_access_controller #(
        .TIMEOUT_CYCLES (Timeout),
        .TIMER_WIDTH    (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .issueValid    (issueValid),
        .load          (load),
        .store         (store),
        .loadUnsigned  (loadUnsigned),
        .memLength     (memLength),
        .address       (address),
        .storeData     (storeData),
        .destReg       (destReg),
        .stall         (stall),
        .memReq        (memReq),
        .memWrite      (memWrite),
        .memAddr       (memAddr),
        .memByteEnable (memByteEnable),
        .memWriteData  (memWriteData),
        .memAck        (memAck),
        .memReadData   (memReadData),
        .wbValid       (wbValid),
        .wbReg         (wbReg),
        .wbData        (wbData),
        .accessError   (accessError)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ld, st, uns;
        logic [1:0]  len;
        logic [31:0] addr, sdata, rdata;
        logic [4:0]  rd;
        int          ack_cycle;  // REQ cycle carrying memAck; 0 = never
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_wb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference model built from access size and byte offset arithmetic.
    task automatic model(input logic ld, input logic st, input logic uns, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, output logic err, output logic [3:0] be,
                         output logic [31:0] wdata, output logic [31:0] wb);
        int size, off;
        logic [31:0] v, mask;
        size = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        off = int'(addr % 4);
        err = (ld && st) || (len == 2'd2) || ((off % size) != 0);
        be = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) wdata[8*i +: 8] = sdata[8*(i % size) +: 8];
        v = rdata >> (8 * off);
        if (size < 4) begin
            mask = (32'h1 << (8 * size)) - 32'h1;
            v = v & mask;
            if (!uns && v[8*size-1]) v = v | ~mask;
        end
        wb = v;
    endtask

    // Drives one op from a mid-cycle point and checks every cycle until idle.
    task automatic run_op(input vec_t v);
        int end_cycle, req_cnt, stall_cnt;
        logic timeout;
        issueValid = 1'b1; load = v.ld; store = v.st; loadUnsigned = v.uns;
        memLength = v.len; address = v.addr; storeData = v.sdata; destReg = v.rd;
        @(negedge clk);
        chk({v.name, " accept stall"}, 32'(stall), 32'(!v.exp_err));
        @(posedge clk); #1;
        issueValid = 1'b0; load = 1'b0; store = 1'b0;
        if (v.exp_err) begin
            @(negedge clk);
            chk({v.name, " err pulse"}, 32'(accessError), 32'd1);
            chk({v.name, " err no req"}, 32'(memReq), 32'd0);
            chk({v.name, " err no stall"}, 32'(stall), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk({v.name, " err single"}, 32'(accessError), 32'd0);
            @(posedge clk); #1;
            return;
        end
        timeout = (v.ack_cycle == 0) || (v.ack_cycle > int'(Timeout));
        end_cycle = timeout ? int'(Timeout) : v.ack_cycle;
        req_cnt = 0; stall_cnt = 0;
        for (int c = 1; c <= end_cycle; c++) begin
            memAck = (c == v.ack_cycle);
            memReadData = (c == v.ack_cycle) ? v.rdata : 32'hA5A5_5A5A;
            @(negedge clk);
            if (memReq) req_cnt++;
            if (stall) stall_cnt++;
            if (c == 1) begin
                chk({v.name, " memAddr"}, memAddr, v.addr & ~32'h3);
                chk({v.name, " memByteEnable"}, 32'(memByteEnable), 32'(v.exp_be));
                chk({v.name, " memWrite"}, 32'(memWrite), 32'(v.st));
                if (v.st) chk({v.name, " memWriteData"}, memWriteData, v.exp_wdata);
            end
            @(posedge clk); #1;
            memAck = 1'b0;
        end
        chk({v.name, " req cycles"}, 32'(req_cnt), 32'(end_cycle));
        chk({v.name, " req stall cycles"}, 32'(stall_cnt), 32'(end_cycle));
        @(negedge clk);
        chk({v.name, " req dropped"}, 32'(memReq), 32'd0);
        if (timeout) begin
            chk({v.name, " timeout err"}, 32'(accessError), 32'd1);
            chk({v.name, " timeout stall"}, 32'(stall), 32'd0);
            chk({v.name, " timeout wb"}, 32'(wbValid), 32'd0);
        end else if (v.st) begin
            chk({v.name, " store stall"}, 32'(stall), 32'd0);
            chk({v.name, " store wb"}, 32'(wbValid), 32'd0);
            chk({v.name, " store err"}, 32'(accessError), 32'd0);
        end else begin
            chk({v.name, " wb stall"}, 32'(stall), 32'd1);
            chk({v.name, " wbValid"}, 32'(wbValid), 32'(v.rd != 5'd0));
            chk({v.name, " load err"}, 32'(accessError), 32'd0);
            if (v.rd != 5'd0) begin
                chk({v.name, " wbData"}, wbData, v.exp_wb);
                chk({v.name, " wbReg"}, 32'(wbReg), 32'(v.rd));
            end
            @(posedge clk); #1;
            @(negedge clk);
            chk({v.name, " post wb stall"}, 32'(stall), 32'd0);
            chk({v.name, " post wb valid"}, 32'(wbValid), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        vec_t r;
        int sel;

        // Reset state
        #1;
        chk("rst memReq", 32'(memReq), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst memAddr", memAddr, 32'd0);
        chk("rst memByteEnable", 32'(memByteEnable), 32'd0);
        chk("rst memWriteData", memWriteData, 32'd0);
        chk("rst wbValid", 32'(wbValid), 32'd0);
        chk("rst wbData", wbData, 32'd0);
        chk("rst wbReg", 32'(wbReg), 32'd0);
        chk("rst accessError", 32'(accessError), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        tbl.push_back('{"lb_signed", 1, 0, 0, 2'd0, 32'h1003, 32'h0, 32'h80FF1234, 5'd5, 1,
                        0, 4'b1000, 32'h0, 32'hFFFFFF80});
        tbl.push_back('{"lbu", 1, 0, 1, 2'd0, 32'h1003, 32'h0, 32'h80FF1234, 5'd6, 1,
                        0, 4'b1000, 32'h0, 32'h00000080});
        tbl.push_back('{"sh_ack3", 0, 1, 0, 2'd1, 32'h2002, 32'h0000BEEF, 32'h0, 5'd0, 3,
                        0, 4'b1100, 32'hBEEFBEEF, 32'h0});
        tbl.push_back('{"lw_misaligned", 1, 0, 0, 2'd3, 32'h1001, 32'h0, 32'h0, 5'd1, 1,
                        1, 4'b0000, 32'h0, 32'h0});
        tbl.push_back('{"len2_illegal", 1, 0, 0, 2'd2, 32'h1000, 32'h0, 32'h0, 5'd1, 1,
                        1, 4'b0000, 32'h0, 32'h0});
        tbl.push_back('{"load_and_store", 1, 1, 0, 2'd3, 32'h1000, 32'h0, 32'h0, 5'd1, 1,
                        1, 4'b0000, 32'h0, 32'h0});
        tbl.push_back('{"lw_timeout", 1, 0, 0, 2'd3, 32'h4000, 32'h0, 32'h0, 5'd7, 0,
                        0, 4'b1111, 32'h0, 32'h0});
        tbl.push_back('{"lw_ack_last", 1, 0, 0, 2'd3, 32'h4004, 32'h0, 32'hCAFEF00D, 5'd7, 8,
                        0, 4'b1111, 32'h0, 32'hCAFEF00D});
        tbl.push_back('{"lw_rd0", 1, 0, 0, 2'd3, 32'h5000, 32'h0, 32'hDEADBEEF, 5'd0, 2,
                        0, 4'b1111, 32'h0, 32'h0});
        tbl.push_back('{"lh_upper", 1, 0, 0, 2'd1, 32'h6002, 32'h0, 32'h80017FFF, 5'd9, 1,
                        0, 4'b1100, 32'h0, 32'hFFFF8001});
        tbl.push_back('{"sb_lane1", 0, 1, 0, 2'd0, 32'h7001, 32'h123456AB, 32'h0, 5'd0, 2,
                        0, 4'b0010, 32'hABABABAB, 32'h0});
        tbl.push_back('{"sw", 0, 1, 0, 2'd3, 32'h7000, 32'h11223344, 32'h0, 5'd0, 1,
                        0, 4'b1111, 32'h11223344, 32'h0});
        foreach (tbl[i]) run_op(tbl[i]);

        // Asynchronous reset in the middle of a request
        issueValid = 1'b1; load = 1'b1; memLength = 2'd3; address = 32'h1000; destReg = 5'd3;
        @(posedge clk); #1;
        issueValid = 1'b0; load = 1'b0;
        @(negedge clk);
        chk("pre-reset memReq", 32'(memReq), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async reset memReq", 32'(memReq), 32'd0);
        chk("async reset stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        memAck = 1'b1; memReadData = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("stale ack memReq", 32'(memReq), 32'd0);
        chk("stale ack stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        memAck = 1'b0;
        @(negedge clk);
        chk("stale ack wbValid", 32'(wbValid), 32'd0);
        @(posedge clk); #1;
        r = '{"lw_after_reset", 1, 0, 0, 2'd3, 32'h3000, 32'h0, 32'h12345678, 5'd4, 1,
              0, 4'b1111, 32'h0, 32'h12345678};
        run_op(r);

        // Randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            r.name = $sformatf("rnd%0d", n);
            sel = int'($urandom_range(0, 9));
            r.len = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd3 : 2'd2;
            r.addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (r.len == 2'd1) r.addr[0] = 1'b0;
                if (r.len == 2'd3) r.addr[1:0] = 2'b00;
            end
            sel = int'($urandom_range(0, 9));
            r.ld = (sel <= 5);
            r.st = (sel == 0) || (sel >= 6);
            r.uns = 1'($urandom_range(0, 1));
            r.sdata = $urandom;
            r.rdata = $urandom;
            r.rd = 5'($urandom_range(0, 31));
            sel = int'($urandom_range(0, 9));
            r.ack_cycle = (sel == 0) ? 0 : (sel == 1) ? 8 : int'($urandom_range(1, 4));
            model(r.ld, r.st, r.uns, r.len, r.addr, r.sdata, r.rdata,
                  r.exp_err, r.exp_be, r.exp_wdata, r.exp_wb);
            run_op(r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
